sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0: extra access cycles per SRAM operation (0..15).
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1; reset rst, asynchronous, active-high; clock clk).
REQ-003 SHALL have req_valid (in, 1): request present.
REQ-004 SHALL have req_ready (out, 1): request accepted when req_valid && req_ready at posedge clk.
REQ-005 SHALL have req_we (in, 1): 1 = write, 0 = read.
REQ-006 SHALL have req_addr (in, 20): word address.
REQ-007 SHALL have req_wdata (in, 16): write data.
REQ-008 SHALL have req_be (in, 2): byte enables, active-high; bit0 = [7:0], bit1 = [15:8].
REQ-009 SHALL have rsp_valid (out, 1): one-cycle pulse, read data valid.
REQ-010 SHALL have rsp_rdata (out, 16): read data.
REQ-011 SHALL have the SRAM pins: sram_addr (out, 20), sram_io (inout, 16), sram_ce_b, sram_we_b, sram_oe_b, sram_ub_b, sram_lb_b (out, 1 each, active-low).

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, READ, DONE.
REQ-013 SHALL drive req_ready = 1 only in IDLE with rst low; the block accepts at most one request per operation.
REQ-014 SHALL, on acceptance, register addr, wdata and be, load wait counter = WAIT_CYCLES, and go to WRITE (req_we = 1) or READ (req_we = 0).
REQ-015 SHALL drive all SRAM pins from registers; no combinational path from req_* to pins.
REQ-016 SHALL, in WRITE: ce_b = 0, we_b = 0, oe_b = 1, ub_b = ~be[1], lb_b = ~be[0], sram_addr = latched addr, sram_io = latched wdata.
REQ-017 SHALL, in READ: ce_b = 0, oe_b = 0, we_b = 1, ub_b/lb_b per be, sram_io = high-Z.
REQ-018 SHALL hold WRITE/READ for exactly WAIT_CYCLES+1 cycles; the counter decrements each cycle and the state exits when the counter equals 0.
REQ-019 SHALL, on the last READ cycle, capture sram_io into rsp_rdata; disabled byte lanes SHALL be captured as 8'h00, never X or Z.
REQ-020 SHALL go READ -> DONE; in DONE it SHALL assert rsp_valid for one cycle with all pins deasserted, which provides the bus turnaround cycle, then return to IDLE.
REQ-021 SHALL go WRITE -> DONE with no rsp_valid, giving one idle cycle with we_b = 1, then return to IDLE.
REQ-022 SHALL have read latency of WAIT_CYCLES+2 cycles from the acceptance edge to the rsp_valid edge; a write occupies WAIT_CYCLES+2 cycles before the next acceptance.
REQ-023 SHALL drive sram_io only while in WRITE; sram_oe_b and sram_we_b SHALL never be low in the same cycle.
REQ-024 SHALL, when be = 2'b00, run a full cycle with ub_b = lb_b = 1: memory is unchanged on write, and rsp_rdata = 16'h0000 with rsp_valid still pulsed on read.
REQ-025 SHALL hold rsp_rdata stable after rsp_valid until the next read capture.
REQ-026 SHALL accept address 20'hFFFFF with no special handling; there is no address wrap logic.
REQ-027 SHALL ignore req_* while not in IDLE.

Reset
REQ-028 SHALL, when rst is asserted, immediately enter IDLE and set ce_b = we_b = oe_b = ub_b = lb_b = 1, sram_addr = 0, sram_io = high-Z, rsp_valid = 0, rsp_rdata = 0, req_ready = 0.
REQ-029 SHALL drop an in-flight operation on rst assertion with no rsp_valid; a partially performed write MAY have modified memory.
REQ-030 SHALL raise req_ready on the first clk edge after rst deasserts.

Verification
REQ-031 Write 16'hBEEF to 20'h00010 with be = 11, then read it back -> rsp_valid at acceptance+2 (WAIT_CYCLES = 0), rsp_rdata = 16'hBEEF.
REQ-032 Write 16'h1234 with be = 01 over a location holding 16'hFFFF, then read with be = 11 -> rsp_rdata = 16'hFF34; a read with be = 10 -> 16'hFF00.
REQ-033 WAIT_CYCLES = 3: a read -> oe_b low for exactly 4 cycles and rsp_valid at acceptance+5; req_ready low for 5 cycles.
REQ-034 Back-to-back read then write held on req_valid -> one DONE cycle between oe_b rising and sram_io being driven; no cycle with both we_b and oe_b low (assertion).
REQ-035 Assert rst during the READ cycle -> all pins deasserted in the same cycle, no rsp_valid, req_ready = 1 one cycle after release.
REQ-036 Write to 20'hFFFFF with be = 00 -> memory unchanged; read back returns the prior contents.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Request/response handshake between a client and the async SRAM controller.
interface sram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-outstanding controller for an asynchronous 16-bit SRAM with byte lanes.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus,
  output logic [19:0] sram_addr,
  inout  wire  [15:0] sram_io,
  output logic        sram_ce_b,
  output logic        sram_we_b,
  output logic        sram_oe_b,
  output logic        sram_ub_b,
  output logic        sram_lb_b
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [15:0] rdata_q;
  logic [15:0] rdata_d;
  logic        ce_b_q;
  logic        we_b_q;
  logic        oe_b_q;
  logic        ub_b_q;
  logic        lb_b_q;
  logic        io_oe_q;

  // Disabled lanes are forced to zero so an undriven bus never leaks into rsp_rdata.
  always_comb begin
    rdata_d       = 16'h0000;
    rdata_d[15:8] = be_q[1] ? sram_io[15:8] : 8'h00;
    rdata_d[7:0]  = be_q[0] ? sram_io[7:0]  : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 20'h00000;
      wdata_q     <= 16'h0000;
      be_q        <= 2'b00;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 16'h0000;
      ce_b_q      <= 1'b1;
      we_b_q      <= 1'b1;
      oe_b_q      <= 1'b1;
      ub_b_q      <= 1'b1;
      lb_b_q      <= 1'b1;
      io_oe_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && bus.req_valid) begin
            ready_q <= 1'b0;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt_q   <= WAIT_INIT;
            ce_b_q  <= 1'b0;
            ub_b_q  <= ~bus.req_be[1];
            lb_b_q  <= ~bus.req_be[0];
            if (bus.req_we) begin
              state_q <= WRITE;
              we_b_q  <= 1'b0;
              io_oe_q <= 1'b1;
            end else begin
              state_q <= READ;
              oe_b_q  <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            ce_b_q  <= 1'b1;
            we_b_q  <= 1'b1;
            ub_b_q  <= 1'b1;
            lb_b_q  <= 1'b1;
            io_oe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        READ: begin
          if (cnt_q == 4'd0) begin
            state_q     <= DONE;
            rdata_q     <= rdata_d;
            rsp_valid_q <= 1'b1;
            ce_b_q      <= 1'b1;
            oe_b_q      <= 1'b1;
            ub_b_q      <= 1'b1;
            lb_b_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Turnaround cycle: every strobe is high before the next access can start.
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

  assign sram_addr = addr_q;
  assign sram_ce_b = ce_b_q;
  assign sram_we_b = we_b_q;
  assign sram_oe_b = oe_b_q;
  assign sram_ub_b = ub_b_q;
  assign sram_lb_b = lb_b_q;
  assign sram_io   = io_oe_q ? wdata_q : 16'hzzzz;

endmodule
